// File: rtl/telemetry_framer.sv
// Periodically snapshots NumCh channels and streams them as a byte frame (raw or ASCII hex) closed by Terminator.
// First byte is valid one cycle after the capture edge, then one byte per accepted cycle; doData holds under backpressure.
module telemetry_framer #(
  parameter int NumCh = 2,
  parameter int ChWidth = 8,
  parameter int Period = 5_000_000,
  parameter logic [7:0] Terminator = 8'h7E,
  parameter int HexMode = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NumCh*ChWidth-1:0] chData,
  output logic                     tick,
  output logic [7:0]               doData,
  output logic                     doValid,
  input  logic                     doReady,
  output logic [7:0]               overrun
);

  localparam int BytesPerCh = ChWidth / 8;
  localparam int NumRaw = NumCh * BytesPerCh;
  localparam int NumOut = (HexMode != 0) ? 2 * NumRaw : NumRaw;
  localparam int IdxW = $clog2(NumOut + 1);
  localparam int CntW = $clog2(Period);
  localparam logic [CntW-1:0] CntMax = CntW'(Period - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumOut - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSend = 2'd1;
  localparam logic [1:0] StTerm = 2'd2;

  logic [CntW-1:0]          cnt;
  logic [1:0]               state;
  logic [IdxW-1:0]          idx;
  logic [IdxW-1:0]          rawIdx;
  logic [NumCh*ChWidth-1:0] snapshot;
  logic [7:0]               curRaw;
  logic                     wrap;
  logic                     accept;

  function automatic logic [7:0] hexChar(input logic [3:0] nib);
    hexChar = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  assign wrap = enable && (cnt == CntMax);
  assign accept = doValid && doReady;
  assign rawIdx = (HexMode != 0) ? (idx >> 1) : idx;

  // Channel 0 leads; inside a channel the most-significant byte leads.
  always_comb begin
    curRaw = 8'h00;
    for (int c = 0; c < NumCh; c++) begin
      for (int j = 0; j < BytesPerCh; j++) begin
        if (rawIdx == IdxW'(c * BytesPerCh + j)) begin
          curRaw = snapshot[c*ChWidth + (BytesPerCh-1-j)*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    doValid = (state != StIdle);
    doData = 8'h00;
    if (state == StSend) begin
      if (HexMode != 0) begin
        doData = idx[0] ? hexChar(curRaw[3:0]) : hexChar(curRaw[7:4]);
      end else begin
        doData = curRaw;
      end
    end else if (state == StTerm) begin
      doData = Terminator;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      tick <= 1'b0;
    end else if (!enable) begin
      cnt <= '0;
      tick <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      tick <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= StIdle;
      idx <= '0;
      snapshot <= '0;
      overrun <= 8'h00;
    end else begin
      // A period boundary that finds a frame still in flight is dropped and counted.
      if (wrap && (state != StIdle) && (overrun != 8'hFF)) begin
        overrun <= overrun + 8'd1;
      end
      case (state)
        StIdle: begin
          if (wrap) begin
            snapshot <= chData;
            idx <= '0;
            state <= StSend;
          end
        end
        StSend: begin
          if (accept) begin
            if (idx == LastIdx) begin
              state <= StTerm;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        StTerm: begin
          if (accept) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_telemetry_framer.sv
// Directed bench for telemetry_framer: four parameterisations share clk and rst.
module tb_telemetry_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         enAB, enC, enD;
  logic [15:0]  chAB, chC;
  logic [255:0] chD;
  logic         readyA, readyB, readyC, readyD;
  logic         tickA, tickB, tickC, tickD;
  logic [7:0]   doA, doB, doC, doD;
  logic         vA, vB, vC, vD;
  logic [7:0]   ovA, ovB, ovC, ovD;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  telemetry_framer #(.NumCh(2), .ChWidth(8), .Period(16), .Terminator(8'h7E), .HexMode(0)) dutA (
    .clk(clk), .rst(rst), .enable(enAB), .chData(chAB), .tick(tickA),
    .doData(doA), .doValid(vA), .doReady(readyA), .overrun(ovA));
  telemetry_framer #(.NumCh(2), .ChWidth(8), .Period(16), .Terminator(8'h7E), .HexMode(1)) dutB (
    .clk(clk), .rst(rst), .enable(enAB), .chData(chAB), .tick(tickB),
    .doData(doB), .doValid(vB), .doReady(readyB), .overrun(ovB));
  telemetry_framer #(.NumCh(1), .ChWidth(16), .Period(16), .Terminator(8'h7E), .HexMode(0)) dutC (
    .clk(clk), .rst(rst), .enable(enC), .chData(chC), .tick(tickC),
    .doData(doC), .doValid(vC), .doReady(readyC), .overrun(ovC));
  telemetry_framer #(.NumCh(8), .ChWidth(32), .Period(4), .Terminator(8'h7E), .HexMode(0)) dutD (
    .clk(clk), .rst(rst), .enable(enD), .chData(chD), .tick(tickD),
    .doData(doD), .doValid(vD), .doReady(readyD), .overrun(ovD));

  typedef struct packed {
    logic [15:0] data;
    logic [23:0] raw;
    logic [39:0] hex;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic tickOf(input int which);
    case (which)
      0: tickOf = tickA;
      1: tickOf = tickB;
      2: tickOf = tickC;
      default: tickOf = tickD;
    endcase
  endfunction

  task automatic waitTick(input int which, input int limit, output int n);
    n = 0;
    while (!tickOf(which) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("tick_arrives", 32'(tickOf(which)), 32'd1);
  endtask

  initial begin
    int n;
    int lastTick;
    int bad;

    vecs[0] = '{16'hB2A1, 24'hA1B27E, 40'h413142327E};
    vecs[1] = '{16'h0000, 24'h00007E, 40'h303030307E};
    vecs[2] = '{16'hFF09, 24'h09FF7E, 40'h303946467E};
    vecs[3] = '{16'h5A7E, 24'h7E5A7E, 40'h374535417E};
    vecs[4] = '{16'hC3F0, 24'hF0C37E, 40'h463043337E};

    rst = 1'b1;
    enAB = 1'b0; enC = 1'b0; enD = 1'b0;
    readyA = 1'b1; readyB = 1'b1; readyC = 1'b1; readyD = 1'b1;
    chAB = vecs[0].data;
    chC = 16'h1234;
    chD = '0;
    for (int c = 0; c < 8; c++)
      for (int j = 0; j < 4; j++)
        chD[c*32 + (3-j)*8 +: 8] = 8'(c*4 + j);

    repeat (3) @(negedge clk);
    check("rst_tick", 32'(tickA), 32'd0);
    check("rst_valid", 32'(vA), 32'd0);
    check("rst_do", 32'(doA), 32'd0);
    check("rst_overrun", 32'(ovA), 32'd0);
    check("rst_validD", 32'(vD), 32'd0);

    rst = 1'b0;
    enAB = 1'b1;
    lastTick = cyc;

    // Raw and hex frames for each table entry; chData is scrambled mid-frame.
    for (int i = 0; i < 5; i++) begin
      chAB = vecs[i].data;
      waitTick(0, 40, n);
      check("tick_period", 32'(cyc - lastTick), 32'd16);
      lastTick = cyc;
      check("tickB_aligned", 32'(tickB), 32'd1);
      for (int k = 0; k < 5; k++) begin
        if (k < 3) begin
          check("rawA_valid", 32'(vA), 32'd1);
          check("rawA_byte", 32'(doA), 32'(8'(vecs[i].raw >> (8*(2-k)))));
        end else begin
          check("rawA_idle", 32'(vA), 32'd0);
        end
        check("hexB_valid", 32'(vB), 32'd1);
        check("hexB_byte", 32'(doB), 32'(8'(vecs[i].hex >> (8*(4-k)))));
        if (k == 1) check("tick_one_cycle", 32'(tickA), 32'd0);
        if (k == 0) chAB = ~vecs[i].data;
        @(negedge clk);
      end
      check("hexB_idle", 32'(vB), 32'd0);
      check("overrunA_zero", 32'(ovA), 32'd0);
    end

    // Enable dropped during SEND: frame still completes, then silence.
    chAB = 16'hB2A1;
    waitTick(1, 40, n);
    for (int k = 0; k < 5; k++) begin
      check("dis_hex_byte", 32'(doB), 32'(8'(vecs[0].hex >> (8*(4-k)))));
      check("dis_hex_valid", 32'(vB), 32'd1);
      if (k == 0) enAB = 1'b0;
      @(negedge clk);
    end
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (tickB || vB || tickA || vA) bad++;
      @(negedge clk);
    end
    check("dis_quiet", 32'(bad), 32'd0);

    // Backpressure: doData holds for five stalled cycles.
    readyC = 1'b0;
    enC = 1'b1;
    waitTick(2, 40, n);
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 32'(vC), 32'd1);
      check("stall_hold", 32'(doC), 32'h12);
      @(negedge clk);
    end
    readyC = 1'b1;
    check("bp_b0", 32'(doC), 32'h12);
    @(negedge clk);
    check("bp_b1", 32'(doC), 32'h34);
    check("bp_b1_valid", 32'(vC), 32'd1);
    @(negedge clk);
    check("bp_term", 32'(doC), 32'h7E);
    @(negedge clk);
    check("bp_idle", 32'(vC), 32'd0);
    enC = 1'b0;

    // Frame longer than the period: skipped ticks counted, no interleaving.
    enD = 1'b1;
    waitTick(3, 20, n);
    for (int b = 0; b < 33; b++) begin
      check("long_valid", 32'(vD), 32'd1);
      check("long_byte", 32'(doD), (b < 32) ? 32'(b) : 32'h7E);
      @(negedge clk);
    end
    check("long_idle", 32'(vD), 32'd0);
    check("overrun_8", 32'(ovD), 32'd8);
    waitTick(3, 10, n);
    check("long_restart_gap", 32'(n), 32'd3);
    check("long_restart_byte", 32'(doD), 32'd0);
    repeat (34) @(negedge clk);
    check("overrun_16", 32'(ovD), 32'd16);
    repeat (1500) @(negedge clk);
    check("overrun_sat", 32'(ovD), 32'd255);

    // Reset on byte 2 aborts the frame; next frame Period cycles later.
    enAB = 1'b1;
    waitTick(0, 40, n);
    check("abort_b0", 32'(doA), 32'hA1);
    @(negedge clk);
    check("abort_b1", 32'(doA), 32'hB2);
    rst = 1'b1;
    @(negedge clk);
    check("abort_valid", 32'(vA), 32'd0);
    check("abort_do", 32'(doA), 32'd0);
    check("abort_ovA", 32'(ovA), 32'd0);
    check("abort_ovD", 32'(ovD), 32'd0);
    rst = 1'b0;
    waitTick(0, 40, n);
    check("abort_restart", 32'(n), 32'd16);
    check("after_b0", 32'(doA), 32'hA1);
    @(negedge clk);
    check("after_b1", 32'(doA), 32'hB2);
    @(negedge clk);
    check("after_term", 32'(doA), 32'h7E);
    @(negedge clk);
    check("after_idle", 32'(vA), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/telemetry_framer.md
TELEMETRY_FRAMER -- requirements
Module: telemetry_framer

Interface
REQ-001 Parameter NumCh, default 2, number of sampled channels (1..8).
REQ-002 Parameter ChWidth, default 8, bits per channel (8, 16, 24 or 32).
REQ-003 Parameter Period, default 5_000_000, clock cycles between frame starts (>= 4).
REQ-004 Parameter Terminator, default 8'h7E, byte closing every frame.
REQ-005 Parameter HexMode, default 0: 0 sends raw bytes, 1 sends two upper-case ASCII hex characters per byte.
REQ-006 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 enable  input  1  periodic framing allowed when high.
REQ-009 chData  input  NumCh*ChWidth  channel values; channel 0 is the least-significant slice.
REQ-010 tick  output  1  one-cycle strobe per period; advances the upstream data source.
REQ-011 do  output  8  byte to the downstream char FIFO / UART.
REQ-012 doValid  output  1  do holds a valid byte.
REQ-013 doReady  input  1  downstream accepts the byte when doValid and doReady are both high.
REQ-014 overrun  output  8  saturating count of skipped frames.

Function
REQ-015 Period counter SHALL count 0..Period-1 while enable is high and hold at 0 while enable is low.
REQ-016 On the edge where the counter equals Period-1, the counter SHALL wrap to 0 and tick SHALL be high for exactly the next cycle.
REQ-017 On that edge, if the FSM is IDLE, chData SHALL be captured into a snapshot register and the FSM SHALL enter SEND.
REQ-018 FSM states: IDLE, SEND, TERM; SEND→TERM after the last data byte is accepted; TERM→IDLE once Terminator is accepted.
REQ-019 Byte order: channel 0 first; within a channel, most-significant byte first; in HexMode, high nibble first.
REQ-020 Frame length SHALL be NumCh*ChWidth/8*(HexMode?2:1)+1 bytes, Terminator included.
REQ-021 doValid SHALL rise in the same cycle as tick, i.e. one cycle after the capture edge.
REQ-022 do SHALL remain stable while doValid is high and doReady is low; no byte is dropped or repeated.
REQ-023 After an accepted byte, the next byte SHALL be presented in the following cycle (one byte per cycle at full throughput).
REQ-024 A tick occurring while the FSM is not IDLE SHALL skip that frame and increment overrun, saturating at 255; the in-flight frame is unaffected.
REQ-025 Deasserting enable mid-frame SHALL let the current frame complete; no new frame starts.
REQ-026 Snapshot SHALL not change during a frame, regardless of chData activity.
REQ-027 Hex encoding: nibble 0-9 maps to 8'h30-8'h39 and nibble A-F maps to 8'h41-8'h46.

Reset
REQ-028 While rst is high: counter=0, FSM=IDLE, tick=0, doValid=0, do=8'h00, overrun=0, snapshot=0.
REQ-029 rst mid-frame SHALL abort the frame immediately; the first frame after reset starts Period cycles after rst falls with enable high.

Verification
REQ-030 NumCh=2, ChWidth=8, Period=16, raw mode, chData=16'hB2A1, doReady=1: tick every 16 cycles -> bytes A1, B2, 7E on 3 consecutive cycles.
REQ-031 Same setup with HexMode=1 -> bytes 41, 31, 42, 32, 7E.
REQ-032 ChWidth=16, NumCh=1, chData=16'h1234, doReady low for 5 cycles after doValid -> do holds 8'h12 throughout; then 12, 34, 7E.
REQ-033 Period=4, NumCh=8, ChWidth=32, doReady=1 (frame length 33 bytes > 4) -> frames not interleaved; overrun increments per skipped tick and saturates at 255.
REQ-034 rst asserted on byte 2 of a frame -> doValid=0 on the next cycle, overrun=0, next frame intact and Period cycles later.
REQ-035 enable dropped during SEND -> current frame ends with 7E, then no tick and no doValid while enable stays low.
